codma_bus_arbiter: RTL and testbench

- Arbitrates the single shared 64-bit memory bus between the codma read machine and write machine. It sits directly downstream of both machines.
- Accepts a request plus transfer size from each machine and grants one at a time, round-robin.
- Holds the grant until the expected number of 64-bit beats completes, then reports done.
- Aborts with an error on a slave error, an illegal size or a stalled transfer.

---
 rtl/codma_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_codma_bus_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/codma_bus_arbiter.sv
// Round-robin owner of the shared 64-bit codma memory bus between the read and write machines.
// A grant is held until the decoded number of beats completes, or until a slave error or a stall aborts it.
module codma_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       rd_req_i,
    input  logic [3:0] rd_size_i,
    input  logic       wr_req_i,
    input  logic [3:0] wr_size_i,
    input  logic       beat_i,
    input  logic       slv_error_i,
    output logic       rd_grant_o,
    output logic       wr_grant_o,
    output logic [3:0] bus_size_o,
    output logic [2:0] beat_count_o,
    output logic       done_o,
    output logic       error_o,
    output logic       owner_o
);

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_DONE} arb_state_t;

    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Beats per size code; zero marks an illegal code.
    function automatic logic [2:0] f_beats(input logic [3:0] size);
        case (size)
            4'd3:    f_beats = 3'd1;
            4'd8:    f_beats = 3'd2;
            4'd9:    f_beats = 3'd4;
            default: f_beats = 3'd0;
        endcase
    endfunction

    arb_state_t       r_state;
    logic             r_rd_grant;
    logic             r_wr_grant;
    logic [3:0]       r_size;
    logic [2:0]       r_cnt;
    logic             r_done;
    logic             r_err;
    logic             r_owner;
    logic             r_last_owner;
    logic [CNT_W-1:0] r_stall;

    logic       w_sel_valid;
    logic       w_sel_wr;
    logic [3:0] w_sel_size;
    logic [2:0] w_sel_beats;
    logic [2:0] w_need;

    // On a tie the machine that did not own the bus last wins.
    assign w_sel_valid = rd_req_i | wr_req_i;
    assign w_sel_wr    = wr_req_i & (~rd_req_i | ~r_last_owner);
    assign w_sel_size  = w_sel_wr ? wr_size_i : rd_size_i;
    assign w_sel_beats = f_beats(w_sel_size);
    assign w_need      = f_beats(r_size);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= ARB_IDLE;
            r_rd_grant   <= 1'b0;
            r_wr_grant   <= 1'b0;
            r_size       <= 4'd0;
            r_cnt        <= 3'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_stall      <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_sel_valid) begin
                        r_last_owner <= w_sel_wr;
                        if (w_sel_beats != 3'd0) begin
                            r_state    <= ARB_GRANT;
                            r_rd_grant <= ~w_sel_wr;
                            r_wr_grant <= w_sel_wr;
                            r_size     <= w_sel_size;
                            r_cnt      <= 3'd0;
                            r_stall    <= '0;
                            r_owner    <= w_sel_wr;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ARB_GRANT: begin
                    // Count reaches the target on one edge; the grant drops on the next.
                    if (slv_error_i || (!beat_i && r_cnt != w_need && r_stall == STALL_LAST)) begin
                        r_state    <= ARB_IDLE;
                        r_err      <= 1'b1;
                        r_rd_grant <= 1'b0;
                        r_wr_grant <= 1'b0;
                        r_size     <= 4'd0;
                        r_cnt      <= 3'd0;
                    end else if (r_cnt == w_need) begin
                        r_state    <= ARB_DONE;
                        r_done     <= 1'b1;
                        r_rd_grant <= 1'b0;
                        r_wr_grant <= 1'b0;
                        r_size     <= 4'd0;
                        r_cnt      <= 3'd0;
                    end else if (beat_i) begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_stall <= '0;
                    end else begin
                        r_stall <= r_stall + CNT_W'(1);
                    end
                end
                ARB_DONE: r_state <= ARB_IDLE;
                default:  r_state <= ARB_IDLE;
            endcase
        end
    end

    assign rd_grant_o   = r_rd_grant;
    assign wr_grant_o   = r_wr_grant;
    assign bus_size_o   = r_size;
    assign beat_count_o = r_cnt;
    assign done_o       = r_done;
    assign error_o      = r_err;
    assign owner_o      = r_owner;

endmodule

// File: tb/tb_codma_bus_arbiter.sv
// Bench for codma_bus_arbiter: directed scenarios plus random traffic, all checked cycle by cycle
// against a transaction-level reference model.
module tb_codma_bus_arbiter;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_req, wr_req, beat, serr;
    logic [3:0] rd_size, wr_size;
    logic       rd_grant, wr_grant, done, err, owner;
    logic [3:0] bus_size;
    logic [2:0] beat_cnt;

    codma_bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .rd_req_i(rd_req), .rd_size_i(rd_size),
        .wr_req_i(wr_req), .wr_size_i(wr_size),
        .beat_i(beat), .slv_error_i(serr),
        .rd_grant_o(rd_grant), .wr_grant_o(wr_grant),
        .bus_size_o(bus_size), .beat_count_o(beat_cnt),
        .done_o(done), .error_o(err), .owner_o(owner)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bus phase (0 free, 1 transfer, 2 turnaround) plus expected outputs.
    int m_phase, m_stall, m_picked, e_size, e_cnt;
    bit m_last, e_rdg, e_wrg, e_done, e_err, e_owner;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int beats_of(input int s);
        case (s)
            3:       return 1;
            8:       return 2;
            9:       return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_stall = 0; m_picked = 0; m_last = 1'b1;
        e_size = 0; e_cnt = 0; e_rdg = 0; e_wrg = 0; e_done = 0; e_err = 0; e_owner = 0;
    endtask

    task automatic model_end(input bit ok);
        m_phase = ok ? 2 : 0;
        e_done = ok; e_err = !ok;
        e_rdg = 0; e_wrg = 0; e_size = 0; e_cnt = 0;
    endtask

    task automatic model_step();
        bit pick_wr;
        int sz;
        m_picked = 0; e_done = 0; e_err = 0;
        if (m_phase == 0) begin
            if (rd_req || wr_req) begin
                pick_wr  = (rd_req && wr_req) ? !m_last : wr_req;
                sz       = pick_wr ? int'(wr_size) : int'(rd_size);
                m_picked = pick_wr ? 2 : 1;
                m_last   = pick_wr;
                if (beats_of(sz) > 0) begin
                    m_phase = 1; m_stall = 0;
                    e_rdg = !pick_wr; e_wrg = pick_wr; e_owner = pick_wr;
                    e_size = sz; e_cnt = 0;
                end else begin
                    e_err = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (serr) model_end(0);
            else if (e_cnt == beats_of(e_size)) model_end(1);
            else if (beat) begin e_cnt++; m_stall = 0; end
            else if (m_stall + 1 == TO) model_end(0);
            else m_stall++;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic check_all();
        chk("rd_grant", 32'(rd_grant), 32'(e_rdg));
        chk("wr_grant", 32'(wr_grant), 32'(e_wrg));
        chk("bus_size", 32'(bus_size), 32'(e_size));
        chk("beat_count", 32'(beat_cnt), 32'(e_cnt));
        chk("done", 32'(done), 32'(e_done));
        chk("error", 32'(err), 32'(e_err));
        chk("owner", 32'(owner), 32'(e_owner));
        chk("grant_mutex", 32'(rd_grant & wr_grant), 32'd0);
        chk("done_err_mutex", 32'(done & err), 32'd0);
    endtask

    // Drive one cycle of inputs, let the edge happen, compare at the following falling edge.
    task automatic cyc(input bit rq, input int rs, input bit wq, input int ws, input bit bt, input bit se);
        rd_req = rq; rd_size = 4'(rs); wr_req = wq; wr_size = 4'(ws); beat = bt; serr = se;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rd_req = 0; wr_req = 0; rd_size = 0; wr_size = 0; beat = 0; serr = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1;
    endtask

    function automatic int rand_size();
        case ($urandom_range(0, 7))
            0:       return int'($urandom_range(0, 15));
            1, 2:    return 3;
            3, 4:    return 8;
            default: return 9;
        endcase
    endfunction

    initial begin
        int  order[$];
        bit  prev_g;
        int  gap, min_gap;
        bit  rq, wq, bt, se;
        int  rs, ws;

        // Read size 9, four beats, then done
        do_reset();
        cyc(1, 9, 0, 0, 0, 0);
        chk("t1_grant", 32'(rd_grant), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 0, 0, 1, 0);
            chk("t1_count", 32'(beat_cnt), 32'(i));
        end
        cyc(0, 0, 0, 0, 1, 0);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_drop", 32'(rd_grant), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t1_done_pulse", 32'(done), 32'd0);

        // Both requesting size 3: read, write, read with idle gaps
        do_reset();
        prev_g = 0; gap = 0; min_gap = 99;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 3, 1, 3, 1, 0);
            if ((rd_grant | wr_grant) && !prev_g) begin
                if (order.size() > 0 && gap < min_gap) min_gap = gap;
                order.push_back(int'(wr_grant));
            end
            if (!(rd_grant | wr_grant)) gap++; else gap = 0;
            prev_g = rd_grant | wr_grant;
        end
        chk("t2_ngrants", 32'(order.size() >= 3), 32'd1);
        if (order.size() >= 3) begin
            chk("t2_first", 32'(order[0]), 32'd0);
            chk("t2_second", 32'(order[1]), 32'd1);
            chk("t2_third", 32'(order[2]), 32'd0);
        end
        chk("t2_gap", 32'(min_gap >= 2), 32'd1);

        // Write size 8, slave error on the second beat
        do_reset();
        cyc(0, 0, 1, 8, 0, 0);
        chk("t3_grant", 32'(wr_grant), 32'd1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 1);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_nodone", 32'(done), 32'd0);
        chk("t3_drop", 32'(wr_grant), 32'd0);

        // Illegal read size rejected, pending write then granted
        do_reset();
        cyc(1, 5, 1, 3, 0, 0);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_no_rd", 32'(rd_grant), 32'd0);
        cyc(0, 0, 1, 3, 0, 0);
        chk("t4_err_once", 32'(err), 32'd0);
        chk("t4_wr_grant", 32'(wr_grant), 32'd1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Stall timeout
        do_reset();
        cyc(1, 9, 0, 0, 0, 0);
        for (int k = 1; k <= TO; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            if (k == TO - 1) begin
                chk("t5_hold", 32'(rd_grant), 32'd1);
                chk("t5_early", 32'(err), 32'd0);
            end
        end
        chk("t5_timeout", 32'(err), 32'd1);
        chk("t5_drop", 32'(rd_grant), 32'd0);

        // Asynchronous reset mid-transfer
        do_reset();
        cyc(0, 0, 1, 9, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        #2 rst_n = 0;
        #1;
        chk("t6_grant", 32'(rd_grant | wr_grant), 32'd0);
        chk("t6_size", 32'(bus_size), 32'd0);
        chk("t6_count", 32'(beat_cnt), 32'd0);
        chk("t6_flags", 32'({done, err, owner}), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // Random traffic, then a beat-starved window that forces timeouts
        rq = 0; wq = 0; rs = 0; ws = 0;
        for (int i = 0; i < 2300; i++) begin
            if (rq && m_picked == 1) rq = 0;
            else if (!rq && $urandom_range(0, 2) == 0) begin rq = 1; rs = rand_size(); end
            if (wq && m_picked == 2) wq = 0;
            else if (!wq && $urandom_range(0, 2) == 0) begin wq = 1; ws = rand_size(); end
            bt = (i < 2000) ? ($urandom_range(0, 9) < 6) : 1'b0;
            se = (i < 2000) ? ($urandom_range(0, 29) == 0) : 1'b0;
            cyc(rq, rs, wq, ws, bt, se);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
